// File: rtl/pipeline_ifq.sv
// Instruction fetch queue between fetch and decode: DEPTH-entry {pc, instr} ring
// with flush-to-empty on taken branches and a sticky overflow flag.
module pipeline_ifq #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_pc_i,
    input  logic [WIDTH-1:0]         push_instr_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         pc_o,
    output logic [WIDTH-1:0]         pcplus4_o,
    output logic [WIDTH-1:0]         instr_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } entry_t;

    entry_t [DEPTH-1:0] mem_q;
    logic   [AW-1:0]    rp_q, rp_d, wp_q, wp_d;
    logic   [CW-1:0]    count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               acc_push, acc_pop;
    entry_t             head;

    always_comb begin
        valid_o  = (count_q != '0);
        full_o   = (count_q == CW'(DEPTH));
        acc_push = push_i && !full_o && !flush_i;
        acc_pop  = pop_i && valid_o && !flush_i;

        rp_d    = rp_q;
        wp_d    = wp_q;
        count_d = count_q;
        ovf_d   = ovf_q | (push_i && full_o && !flush_i);

        if (flush_i) begin
            rp_d    = '0;
            wp_d    = '0;
            count_d = '0;
        end else begin
            if (acc_push) wp_d = wp_q + AW'(1);
            if (acc_pop)  rp_d = rp_q + AW'(1);
            count_d = count_q + CW'(acc_push) - CW'(acc_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rp_q    <= '0;
            wp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset; an empty queue masks the head to zero.
    always_ff @(posedge clk_i) begin
        if (acc_push) mem_q[wp_q] <= '{pc: push_pc_i, instr: push_instr_i};
    end

    always_comb begin
        head      = mem_q[rp_q];
        pc_o      = valid_o ? head.pc    : '0;
        instr_o   = valid_o ? head.instr : '0;
        pcplus4_o = pc_o + WIDTH'(4);
        count_o   = count_q;
        ovf_o     = ovf_q;
    end
endmodule

// File: tb/tb_pipeline_ifq.sv
// Bench for pipeline_ifq: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipeline_ifq;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clk = 0;
    logic             reset, push, pop, flush;
    logic [WIDTH-1:0] push_pc, push_instr;
    logic             valid_o, full_o, ovf_o;
    logic [WIDTH-1:0] pc_o, pcplus4_o, instr_o;
    logic [2:0]       count_o;

    int errs = 0;
    int checks = 0;
    bit chk_en = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t mq[$];
    bit   movf;

    pipeline_ifq #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_i(clk), .reset_i(reset), .push_i(push), .push_pc_i(push_pc),
        .push_instr_i(push_instr), .pop_i(pop), .flush_i(flush),
        .valid_o(valid_o), .pc_o(pc_o), .pcplus4_o(pcplus4_o), .instr_o(instr_o),
        .full_o(full_o), .count_o(count_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO queue of entries.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            movf = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            bit was_full, was_empty;
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            if (push && was_full) movf = 1;
            if (pop && !was_empty) void'(mq.pop_front());
            if (push && !was_full) mq.push_back('{pc: push_pc, instr: push_instr});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] epc, ein;
            epc = (mq.size() != 0) ? mq[0].pc : 32'h0;
            ein = (mq.size() != 0) ? mq[0].instr : 32'h0;
            chk("m_valid", 32'(valid_o), 32'(mq.size() != 0));
            chk("m_pc", pc_o, epc);
            chk("m_instr", instr_o, ein);
            chk("m_pcplus4", pcplus4_o, epc + 32'd4);
            chk("m_full", 32'(full_o), 32'(mq.size() == DEPTH));
            chk("m_count", 32'(count_o), 32'(mq.size()));
            chk("m_ovf", 32'(ovf_o), 32'(movf));
        end
    end

    function automatic logic [31:0] ins_of(input logic [31:0] p);
        return p ^ 32'hDEAD_0000;
    endfunction

    // One clock: drive inputs, take the edge, settle just after it.
    task automatic cyc(input bit ps, input logic [31:0] p, input bit pp, input bit fl);
        push = ps; push_pc = p; push_instr = ins_of(p); pop = pp; flush = fl;
        @(posedge clk); #1;
        push = 0; pop = 0; flush = 0;
    endtask

    initial begin
        logic [31:0] obs[$];
        int          nxt, cyc_cnt;
        bit          ps, pp;

        reset = 1; push = 0; pop = 0; flush = 0; push_pc = 0; push_instr = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_en = 1;
        reset = 0;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_pcplus4", pcplus4_o, 32'd4);
        chk("rst_ovf", 32'(ovf_o), 32'd0);

        // Fill
        for (int k = 0; k < 4; k++) begin
            cyc(1, 32'(4 * k), 0, 0);
            chk("fill_count", 32'(count_o), 32'(k + 1));
        end
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_pc", pc_o, 32'h0);
        chk("fill_instr", instr_o, 32'hDEAD_0000);

        // Push while full with pop: push dropped, ovf set
        cyc(1, 32'h10, 1, 0);
        chk("ovf_pc", pc_o, 32'h4);
        chk("ovf_count", 32'(count_o), 32'd3);
        chk("ovf_flag", 32'(ovf_o), 32'd1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("ovf_pc_last", pc_o, 32'hC);
        cyc(0, 0, 1, 0);
        chk("ovf_drained", 32'(valid_o), 32'd0);
        chk("ovf_sticky", 32'(ovf_o), 32'd1);

        // Flush with concurrent push
        cyc(1, 32'h20, 0, 0);
        cyc(1, 32'h24, 0, 0);
        cyc(1, 32'h40, 0, 1);
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_instr", instr_o, 32'd0);
        cyc(1, 32'h40, 0, 0);
        chk("flush_repush_pc", pc_o, 32'h40);
        cyc(0, 0, 1, 0);

        // Pop while empty
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 0);
            chk("empty_pop_count", 32'(count_o), 32'd0);
        end
        cyc(1, 32'h80, 0, 0);
        chk("after_empty_pc", pc_o, 32'h80);
        chk("after_empty_pcplus4", pcplus4_o, 32'h84);
        cyc(0, 0, 1, 0);

        // pcplus4 wraps
        cyc(1, 32'hFFFF_FFFC, 0, 0);
        chk("wrap_pcplus4", pcplus4_o, 32'h0);
        cyc(0, 0, 1, 0);

        // Stream 10 entries with random overlap; producer retries when full
        nxt = 0; cyc_cnt = 0;
        while ((nxt < 10 || mq.size() != 0) && cyc_cnt < 200) begin
            ps = (nxt < 10) && ($urandom_range(3) != 0);
            pp = $urandom_range(1);
            if (pp && valid_o) obs.push_back(pc_o);
            if (ps && mq.size() < DEPTH) begin
                cyc(1, 32'h100 + 32'(4 * nxt), pp, 0);
                nxt++;
            end else begin
                cyc(ps, 32'h100 + 32'(4 * nxt), pp, 0);
            end
            cyc_cnt++;
        end
        chk("stream_done", 32'(cyc_cnt < 200), 32'd1);
        chk("stream_len", 32'(obs.size()), 32'd10);
        foreach (obs[i]) chk("stream_order", obs[i], 32'h100 + 32'(4 * i));

        // Random traffic including flush and occasional reset
        for (int k = 0; k < 400; k++) begin
            logic [31:0] p;
            p = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            reset = ($urandom_range(63) == 0);
            cyc($urandom_range(2) != 0, p, $urandom_range(1), $urandom_range(15) == 0);
            reset = 0;
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
